mod_n_divider: RTL and testbench
================================

MOD_N_DIVIDER -- requirements
Module: mod_n_divider

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  8  counter and modulus width in bits.
  RESET_DIV  3  active modulus after reset; legal range 2..2^WIDTH-1.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; every register updates on its rising edge.
  clear  in  1  reset; synchronous and active-low.
  en  in  1  count enable.
  mode  in  1  output shape: 0 = pulse, 1 = square.
  div_in  in  WIDTH  requested modulus.
  div_load  in  1  one-cycle strobe that requests div_in as the new modulus.
  count  out  WIDTH  current count value.
  div_active  out  WIDTH  modulus currently in force (M).
  pending  out  1  a legal request is waiting to be applied.
  tc  out  1  terminal count indicator.
  out  out  1  divided output.
  err  out  1  one-cycle illegal-request flag.

Function
REQ-003 With en=1, count SHALL step 0,1,...,M-1,0 and advance by one per clk.
REQ-004 With en=0, count and out SHALL hold their values and tc SHALL be 0.
REQ-005 tc SHALL equal (count==M-1) AND en.
  - tc is a decode of registered state and en only.
REQ-006 out SHALL be registered, with no combinational path from any input.
  - out SHALL be updated in the same edge as count and SHALL equal f(count, M, mode) of the new count.
REQ-007 In mode 0 (pulse), f SHALL be 1 only when count==M-1.
  - Result: one high cycle per M cycles.
REQ-008 In mode 1 (square), f SHALL be 1 when count >= M - floor(M/2).
  - Result: high for floor(M/2) cycles and low for ceil(M/2) cycles, low phase first.
REQ-009 A mode change SHALL take effect on out at the next clk edge, without disturbing count.
REQ-010 div_load=1 with div_in>=2 SHALL capture div_in into the shadow register and set pending=1.
  - A later load while pending=1 SHALL overwrite the shadow register (last request wins).
REQ-011 div_load=1 with div_in<2 SHALL be rejected.
  - The shadow register and pending SHALL be unchanged.
  - err SHALL be 1 for exactly the following cycle.
REQ-012 On a cycle with tc=1 and pending=1, the next edge SHALL perform all of:
  - load the shadow register into div_active;
  - set count to 0;
  - clear pending.
REQ-013 On a cycle with div_load=1 (legal) and tc=1 together, the new div_in SHALL be applied at that same wrap.
  - Any older shadow value is bypassed.
  - pending SHALL end at 0.
REQ-014 div_active SHALL never change except at a wrap, so no shortened or stretched output period ever occurs.
REQ-015 M=2^WIDTH-1 SHALL work without overflow.
  - count never exceeds M-1.
  - Comparisons SHALL be done at WIDTH bits with no truncation of M-floor(M/2).

Reset
REQ-016 clear=0 at a clk edge SHALL force, regardless of en or div_load:
  - count=0;
  - div_active=RESET_DIV;
  - shadow register=RESET_DIV;
  - pending=0, out=0, err=0.
REQ-017 Reset asserted mid-period SHALL discard any pending request.
  - The first enabled edge after release SHALL take count from 0 to 1.
REQ-018 The block SHALL have no asynchronous reset paths and no clock gating.
  - out is a data signal; it SHALL NOT be used as a clock.

Structure
REQ-019 Package mod_n_divider_pkg SHALL hold:
  - MIN_DIV=2;
  - mode encodings MODE_PULSE=0 and MODE_SQUARE=1;
  - the default WIDTH.
REQ-020 The shadow register, pending and err logic SHALL be one sub-module, mod_n_divider_shadow.
  - The counter and out decode SHALL stay in the top module.
REQ-021 RESET_DIV<2 SHALL be flagged as an elaboration-time error.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, en=1, mode=1, M=3: count cycles 0,1,2; out is high only at count 2; tc fires every 3rd cycle.
  - M=6, mode=1: out is low for 3 cycles then high for 3 cycles; mode=0: out is high 1 cycle in 6.
  - M=5, load div_in=4 at count 1: pending=1; count 2,3,4 completes under M=5; then div_active=4 and 4-cycle periods follow.
  - Load div_in=7 on the tc cycle while pending holds 9: M=7 applies at that wrap; pending ends at 0.
  - Load div_in=1: err is high for one cycle; pending and div_active are unchanged.
  - en=0 for 4 cycles at count 2: count, out and tc hold; then clear=0 mid-period with pending=1 gives all outputs at reset values and pending=0.

Source files
------------

// File: rtl/mod_n_divider_pkg.sv
// mod_n_divider_pkg: shared constants for the modulo-N divider
package mod_n_divider_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int MIN_DIV = 2;
  typedef enum logic {MODE_PULSE = 1'b0, MODE_SQUARE = 1'b1} mode_e;
endpackage

// File: rtl/mod_n_divider_shadow.sv
// mod_n_divider_shadow: requested-modulus shadow register with pending and illegal-request flags
module mod_n_divider_shadow
  import mod_n_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             tc,
  output logic [WIDTH-1:0] new_div,
  output logic             apply,
  output logic             pending,
  output logic             err
);
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic pending_q, pending_d, err_q, err_d, legal;
  always_comb begin
    legal = div_load && div_in >= WIDTH'(MIN_DIV);
    apply = tc && (legal || pending_q);
    new_div = legal ? div_in : shadow_q;
    shadow_d = new_div;
    pending_d = !apply && (legal || pending_q);
    err_d = div_load && !legal;
  end
  always_ff @(posedge clk) begin
    if (!clear) begin
      shadow_q <= WIDTH'(RESET_DIV);
      pending_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      err_q <= err_d;
    end
  end
  assign pending = pending_q;
  assign err = err_q;
endmodule

// File: rtl/mod_n_divider.sv
// mod_n_divider: programmable modulo-N counter with registered pulse/square divided output
module mod_n_divider
  import mod_n_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic             tc,
  output logic             out,
  output logic             err
);
  if (RESET_DIV < MIN_DIV || longint'(RESET_DIV) > (longint'(1) << WIDTH) - 1) begin : g_bad_reset_div
    $error("mod_n_divider: RESET_DIV out of range");
  end
  logic [WIDTH-1:0] count_q, count_d, div_active_q, div_active_d, new_div;
  logic out_q, out_d, apply;
  mod_n_divider_shadow #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) u_shadow (
    .clk(clk),
    .clear(clear),
    .div_in(div_in),
    .div_load(div_load),
    .tc(tc),
    .new_div(new_div),
    .apply(apply),
    .pending(pending),
    .err(err)
  );
  assign tc = en && count_q == div_active_q - WIDTH'(1);
  always_comb begin
    div_active_d = apply ? new_div : div_active_q;
    count_d = !en ? count_q : tc ? '0 : count_q + WIDTH'(1);
    out_d = !en ? out_q
          : mode == MODE_PULSE ? count_d == div_active_d - WIDTH'(1)
          : count_d >= div_active_d - (div_active_d >> 1);
  end
  always_ff @(posedge clk) begin
    if (!clear) begin
      count_q <= '0;
      div_active_q <= WIDTH'(RESET_DIV);
      out_q <= 1'b0;
    end else begin
      count_q <= count_d;
      div_active_q <= div_active_d;
      out_q <= out_d;
    end
  end
  assign count = count_q;
  assign div_active = div_active_q;
  assign out = out_q;
endmodule

// File: tb/tb_mod_n_divider.sv
// tb_mod_n_divider: directed and random checks of mod_n_divider against a behavioural model
module tb_mod_n_divider;
  localparam int W = 8;
  localparam int RD = 3;
  logic clk = 1'b0, clear = 1'b0, en = 1'b0, mode = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic [W-1:0] count, div_active;
  logic pending, tc, out, err;
  int n_cmp = 0, n_bad = 0;
  int m_cnt = 0, m_div = RD, m_sh = RD, m_pend = 0, m_out = 0, m_err = 0;
  int tc_seen = 0;
  int held_out;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  mod_n_divider #(.WIDTH(W), .RESET_DIV(RD)) dut (
    .clk(clk),
    .clear(clear),
    .en(en),
    .mode(mode),
    .div_in(div_in),
    .div_load(div_load),
    .count(count),
    .div_active(div_active),
    .pending(pending),
    .tc(tc),
    .out(out),
    .err(err)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    bit legal, wrap;
    if (!clear) begin
      m_cnt = 0; m_div = RD; m_sh = RD; m_pend = 0; m_out = 0; m_err = 0;
    end else begin
      legal = div_load && int'(div_in) >= 2;
      wrap = en && m_cnt == m_div - 1;
      m_err = (div_load && !legal) ? 1 : 0;
      if (legal) m_sh = int'(div_in);
      if (wrap && (legal || m_pend != 0)) begin
        m_div = m_sh;
        m_pend = 0;
      end else if (legal) m_pend = 1;
      if (en) begin
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (mode) m_out = (m_cnt >= m_div - m_div / 2) ? 1 : 0;
        else m_out = (m_cnt == m_div - 1) ? 1 : 0;
      end
    end
  endtask
  task automatic tick();
    #1;
    tc_seen = int'(tc);
    if (armed) check("tc", tc_seen, (en && m_cnt == m_div - 1) ? 1 : 0);
    @(posedge clk);
    model_edge();
    armed = 1'b1;
    #1;
    check("count", int'(count), m_cnt);
    check("div_active", int'(div_active), m_div);
    check("pending", int'(pending), m_pend);
    check("out", int'(out), m_out);
    check("err", int'(err), m_err);
    @(negedge clk);
    div_load = 1'b0;
  endtask
  task automatic wait_count(input int v);
    for (int i = 0; i < 600 && int'(count) != v; i++) tick();
    check("wait_count", int'(count), v);
  endtask
  task automatic wait_div(input int v);
    for (int i = 0; i < 600 && int'(div_active) != v; i++) tick();
    check("wait_div", int'(div_active), v);
  endtask
  initial begin
    @(negedge clk);
    clear = 1'b0; en = 1'b1; div_load = 1'b1; div_in = 8'd9;
    tick();
    tick();
    check("rst_count", int'(count), 0);
    check("rst_div", int'(div_active), RD);
    check("rst_pend", int'(pending), 0);
    check("rst_out", int'(out), 0);
    check("rst_err", int'(err), 0);
    clear = 1'b1; mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s1_count", int'(count), (i + 1) % 3);
      check("s1_out", int'(out), ((i + 1) % 3 == 2) ? 1 : 0);
      check("s1_tc", tc_seen, (i % 3 == 2) ? 1 : 0);
    end
    div_load = 1'b1; div_in = 8'd6;
    tick();
    wait_div(6);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s2_square", int'(out), ((i + 1) % 6 >= 3) ? 1 : 0);
    end
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s2_pulse", int'(out), ((i + 1) % 6 == 5) ? 1 : 0);
    end
    div_load = 1'b1; div_in = 8'd5;
    tick();
    wait_div(5);
    wait_count(1);
    div_load = 1'b1; div_in = 8'd4;
    tick();
    check("s3_pend", int'(pending), 1);
    check("s3_count", int'(count), 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("s3_old_div", int'(div_active), 5);
      check("s3_old_count", int'(count), 3 + i);
    end
    tick();
    check("s3_new_div", int'(div_active), 4);
    check("s3_wrap_count", int'(count), 0);
    check("s3_pend_clr", int'(pending), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s3_period", int'(count), (i + 1) % 4);
      check("s3_tc", tc_seen, (i % 4 == 3) ? 1 : 0);
    end
    div_load = 1'b1; div_in = 8'd9;
    tick();
    check("s4_pend9", int'(pending), 1);
    wait_count(3);
    div_load = 1'b1; div_in = 8'd7;
    tick();
    check("s4_div", int'(div_active), 7);
    check("s4_pend", int'(pending), 0);
    check("s4_count", int'(count), 0);
    div_load = 1'b1; div_in = 8'd1;
    tick();
    check("s5_err", int'(err), 1);
    check("s5_pend", int'(pending), 0);
    check("s5_div", int'(div_active), 7);
    tick();
    check("s5_err_clr", int'(err), 0);
    wait_count(1);
    div_load = 1'b1; div_in = 8'd5;
    tick();
    check("s6_pend", int'(pending), 1);
    held_out = int'(out);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s6_hold_count", int'(count), 2);
      check("s6_hold_out", int'(out), held_out);
      check("s6_hold_tc", tc_seen, 0);
    end
    clear = 1'b0;
    tick();
    check("s6_rst_count", int'(count), 0);
    check("s6_rst_div", int'(div_active), RD);
    check("s6_rst_pend", int'(pending), 0);
    check("s6_rst_out", int'(out), 0);
    check("s6_rst_err", int'(err), 0);
    clear = 1'b1; en = 1'b1;
    tick();
    check("s6_first", int'(count), 1);
    check("s6_first_div", int'(div_active), RD);
    for (int i = 0; i < 3000; i++) begin
      clear = $urandom_range(99) != 0;
      en = $urandom_range(9) != 0;
      if ($urandom_range(19) == 0) mode = ~mode;
      div_load = $urandom_range(7) == 0;
      case ($urandom_range(9))
        0: div_in = 8'd0;
        1: div_in = 8'd1;
        2: div_in = 8'd255;
        3: div_in = 8'd2;
        default: div_in = W'($urandom_range(3, 12));
      endcase
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
